// File: rtl/conv_sequencer.sv
// Convolution tap sequencer: walks a KxK window over an IN_HxIN_W map and issues
// one buffer read / MAC tap per cycle, then writes each finished output pixel.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; tap counters at zero
// S_RUN    | issuing one tap per non-paused cycle
// S_DRAIN  | last tap in flight; waits for final mac_en and out_we
// S_DONE   | one-cycle done pulse, then back to idle
module conv_sequencer #(
   parameter int IN_W   = 11,
   parameter int IN_H   = 10,
   parameter int K      = 3,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] in_addr,
   output logic [3:0]        w_addr,
   output logic              mac_en,
   output logic              mac_clr,
   output logic              out_we,
   output logic [ADDR_W-1:0] out_addr
);

   localparam int OUT_W = IN_W - K + 1;
   localparam int OUT_H = IN_H - K + 1;
   localparam int KW    = $clog2(K + 1);
   localparam int OXW   = $clog2(OUT_W + 1);
   localparam int OYW   = $clog2(OUT_H + 1);

   localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);
   localparam logic [OXW-1:0] OX_LAST = OXW'(OUT_W - 1);
   localparam logic [OYW-1:0] OY_LAST = OYW'(OUT_H - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state;
   logic [1:0]        drain_cnt;
   logic [KW-1:0]     kx;
   logic [KW-1:0]     ky;
   logic [OXW-1:0]    ox;
   logic [OYW-1:0]    oy;
   logic              tap_first;
   logic              tap_last;
   logic [ADDR_W-1:0] pix_addr;
   logic [ADDR_W-1:0] pix_d1;
   logic              we_d1;

   logic              issue;
   logic              k_wrap;
   logic              pass_last;
   logic [ADDR_W-1:0] in_addr_c;
   logic [3:0]        w_addr_c;
   logic [ADDR_W-1:0] pix_addr_c;

   assign issue      = ((state == S_IDLE) && start) || ((state == S_RUN) && !pause);
   assign k_wrap     = (kx == K_LAST) && (ky == K_LAST);
   assign pass_last  = k_wrap && (ox == OX_LAST) && (oy == OY_LAST);

   assign in_addr_c  = ADDR_W'((int'(oy) + int'(ky)) * IN_W + int'(ox) + int'(kx));
   assign w_addr_c   = 4'(int'(ky) * K + int'(kx));
   assign pix_addr_c = ADDR_W'(int'(oy) * OUT_W + int'(ox));

   assign busy = (state == S_RUN) || (state == S_DRAIN);
   assign done = (state == S_DONE);

   // Tap outputs are registered, so the state register runs one cycle ahead of
   // rd_en; the drain count covers the last tap plus its two pipeline stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         drain_cnt <= 2'd0;
         kx        <= '0;
         ky        <= '0;
         ox        <= '0;
         oy        <= '0;
         rd_en     <= 1'b0;
         in_addr   <= '0;
         w_addr    <= '0;
         pix_addr  <= '0;
         tap_first <= 1'b0;
         tap_last  <= 1'b0;
      end else begin
         rd_en     <= 1'b0;
         tap_first <= 1'b0;
         tap_last  <= 1'b0;

         if (issue) begin
            rd_en     <= 1'b1;
            in_addr   <= in_addr_c;
            w_addr    <= w_addr_c;
            pix_addr  <= pix_addr_c;
            tap_first <= (kx == '0) && (ky == '0);
            tap_last  <= k_wrap;

            if (kx == K_LAST) begin
               kx <= '0;
               if (ky == K_LAST) begin
                  ky <= '0;
                  if (ox == OX_LAST) begin
                     ox <= '0;
                     if (oy == OY_LAST) oy <= '0;
                     else               oy <= oy + 1'b1;
                  end else begin
                     ox <= ox + 1'b1;
                  end
               end else begin
                  ky <= ky + 1'b1;
               end
            end else begin
               kx <= kx + 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (start) state <= S_RUN;
            end
            S_RUN: begin
               if (!pause && pass_last) begin
                  state     <= S_DRAIN;
                  drain_cnt <= 2'd2;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == 2'd0) state <= S_DONE;
               else                   drain_cnt <= drain_cnt - 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mac_en   <= 1'b0;
         mac_clr  <= 1'b0;
         we_d1    <= 1'b0;
         out_we   <= 1'b0;
         pix_d1   <= '0;
         out_addr <= '0;
      end else begin
         mac_en   <= rd_en;
         mac_clr  <= rd_en && tap_first;
         we_d1    <= rd_en && tap_last;
         out_we   <= we_d1;
         pix_d1   <= pix_addr;
         out_addr <= pix_d1;
      end
   end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: buffer + MAC environment model, output
// writes checked against a queue of software-convolution results.
module tb_conv_sequencer;

   localparam int IN_W   = 11;
   localparam int IN_H   = 10;
   localparam int K      = 3;
   localparam int ADDR_W = 7;
   localparam int OUT_W  = IN_W - K + 1;
   localparam int OUT_H  = IN_H - K + 1;
   localparam int NPIX   = OUT_W * OUT_H;
   localparam int NTAP   = NPIX * K * K;

   typedef struct {
      int cyc;
      int addr;
      int sum;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              pause;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] in_addr;
   logic [3:0]        w_addr;
   logic              mac_en;
   logic              mac_clr;
   logic              out_we;
   logic [ADDR_W-1:0] out_addr;
   logic [23:0]       outs;

   int   total = 0;
   int   bad   = 0;
   int   edge_n = 0;
   int   s_edge = 0;
   bit   run_on = 0;
   bit   pmode  = 0;
   int   tap_cnt, mac_cnt, busy_cnt, busy_first, done_cnt, done_cyc;
   exp_t sb[$];

   logic [7:0] in_mem [128];
   logic [7:0] w_mem  [16];
   logic [7:0] in_d = 8'd0;
   logic [7:0] w_d  = 8'd0;
   int         acc  = 0;

   always #5 clk = ~clk;

   conv_sequencer #(.IN_W(IN_W), .IN_H(IN_H), .K(K), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .busy(busy), .done(done), .rd_en(rd_en), .in_addr(in_addr), .w_addr(w_addr),
      .mac_en(mac_en), .mac_clr(mac_clr), .out_we(out_we), .out_addr(out_addr)
   );

   assign outs = {busy, done, rd_en, in_addr, w_addr, mac_en, mac_clr, out_we, out_addr};

   always @(posedge clk) edge_n <= edge_n + 1;

   // Buffers with one-cycle read latency feeding a load/accumulate MAC.
   always @(posedge clk) begin
      in_d <= in_mem[in_addr];
      w_d  <= w_mem[w_addr];
      if (mac_en) acc <= mac_clr ? int'(in_d) * int'(w_d) : acc + int'(in_d) * int'(w_d);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int conv(input int p);
      int ox, oy, s;
      ox = p % OUT_W;
      oy = p / OUT_W;
      s  = 0;
      for (int ky = 0; ky < K; ky++)
         for (int kx = 0; kx < K; kx++)
            s += (((oy + ky) * IN_W + ox + kx) % 256) * (ky * K + kx + 1);
      return s;
   endfunction

   // Cycle c is the interval ending at edge c, sampled at the negedge inside it.
   always @(negedge clk) begin : monitor
      int   rel, ti, pix, kx, ky, ox, oy;
      exp_t e;
      rel = edge_n - s_edge + 1;
      if (rst) begin
         chk("rst_outs", 32'(outs), 32'd0);
      end else if (!run_on) begin
         chk("idle_we", 32'(out_we), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
      end else begin
         if (rd_en) begin
            ti  = tap_cnt;
            kx  = ti % K;
            ky  = (ti / K) % K;
            pix = ti / (K * K);
            ox  = pix % OUT_W;
            oy  = pix / OUT_W;
            chk("in_addr", 32'(in_addr), 32'((oy + ky) * IN_W + ox + kx));
            chk("w_addr", 32'(w_addr), 32'(ky * K + kx));
            tap_cnt++;
         end
         if (pmode && (rel == 6 || rel == 7 || rel == 8 || rel == 13))
            chk("pause_rd_en", 32'(rd_en), 32'd0);
         if (mac_en) mac_cnt++;
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = rel;
         end
         if (done) begin
            done_cnt++;
            done_cyc = rel;
         end
         if (out_we) begin
            if (sb.size() == 0) begin
               chk("we_extra", 32'(out_addr), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("we_cycle", 32'(rel), 32'(e.cyc));
               chk("we_addr", 32'(out_addr), 32'(e.addr));
               chk("we_sum", 32'(acc), 32'(e.sum));
            end
         end
      end
   end

   task automatic wait_rel(input int c);
      while ((edge_n - s_edge) < c - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic begin_pass(input bit pm);
      exp_t e;
      tap_cnt = 0; mac_cnt = 0; busy_cnt = 0; busy_first = -1;
      done_cnt = 0; done_cyc = -1; pmode = pm;
      sb.delete();
      for (int p = 0; p < NPIX; p++) begin
         e.cyc  = 9 * p + 11 + (pm ? ((p == 0) ? 3 : 4) : 0);
         e.addr = p;
         e.sum  = conv(p);
         sb.push_back(e);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      s_edge = edge_n;
      start  = 1'b0;
      run_on = 1'b1;
   endtask

   task automatic end_pass(input int exp_done, input bit poke_start);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("done_timeout", 32'(n < 3000), 32'd1);
      if (poke_start) start = 1'b1;
      wait_rel(exp_done + 1);
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("tap_count", 32'(tap_cnt), 32'(NTAP));
      chk("mac_count", 32'(mac_cnt), 32'(NTAP));
      chk("we_missing", 32'(sb.size()), 32'd0);
      chk("busy_count", 32'(busy_cnt), 32'(exp_done - 1));
      chk("busy_first", 32'(busy_first), 32'd1);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_cyc), 32'(exp_done));
      chk("post_busy", 32'(busy), 32'd0);
      run_on = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) in_mem[i] = 8'(i % 256);
      for (int j = 0; j < 16; j++)  w_mem[j]  = 8'(j + 1);
      rst = 1'b1; start = 1'b0; pause = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);

      // basic pass, with start pulses while busy and during done
      begin_pass(1'b0);
      wait_rel(100); start = 1'b1;
      wait_rel(101); start = 1'b0;
      end_pass(651, 1'b1);

      repeat (4) @(posedge clk);
      #1;
      begin_pass(1'b1);
      wait_rel(5);  pause = 1'b1;
      wait_rel(8);  pause = 1'b0;
      wait_rel(12); pause = 1'b1;
      wait_rel(13); pause = 1'b0;
      end_pass(655, 1'b0);

      // abort mid-pass, then a clean restart
      repeat (3) @(posedge clk);
      #1;
      begin_pass(1'b0);
      wait_rel(300);
      rst    = 1'b1;
      run_on = 1'b0;
      sb.delete();
      #1;
      chk("abort_outs", 32'(outs), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_idle", 32'(busy), 32'd0);
      begin_pass(1'b0);
      end_pass(651, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
